adder_slice_scheduler: RTL and testbench
========================================

# adder_slice_scheduler

Byte-serial sequencer and arbiter that runs 32-bit additions for two requesters through one shared 8-bit adder slice (an `Adder_8bit` instance or equivalent). It replaces the four-slice ripple arrangement where area matters more than throughput. For each granted request it drives the slice four times, byte 0 first, and holds the inter-byte carry in a register. It then returns a 32-bit sum, a carry-out and the requester id through a valid/ready result port.

## Interface
- `ADD_LAT`, default 1: slice latency in cycles from operands presented on `add_*` to `add_sum`/`add_cout` valid. Legal range 0..3; 0 means a combinational slice.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `r0_valid`, `r1_valid` in 1 each: request pending.
- `r0_ready`, `r1_ready` out 1 each: request accepted this cycle.
- `r0_a`, `r0_b`, `r1_a`, `r1_b` in 32 each: operands.
- `r0_cin`, `r1_cin` in 1 each: carry-in.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_sum` out 32: sum, computed as (a+b+cin) mod 2^32.
- `res_carry` out 1: carry out of bit 31.
- `res_id` out 1: requester that issued the op.
- `add_a`, `add_b` out 8 each: slice operands.
- `add_cin` out 1: slice carry-in.
- `add_sum` in 8: slice sum.
- `add_cout` in 1: slice carry-out.

## Operation
- **FSM states:** IDLE, ISSUE, DONE. The byte index `idx` (2 bits) and the wait counter `wcnt` (0..ADD_LAT) are sub-state registers of ISSUE.
- **IDLE arbitration:**
  - If exactly one `rN_valid` is high, that requester is granted.
  - If both are high, the requester other than `last_id` is granted.
  - `rN_ready` is asserted combinationally for the granted requester only, in IDLE only.
- **Accept (IDLE, valid & ready):** at the edge, latch a, b and id, set `carry_reg` to cin, set `idx` to 0, `wcnt` to 0 and `last_id` to the granted id, then go to ISSUE.
- **ISSUE drive:** `add_a` = A[8·idx+7 : 8·idx], `add_b` = B[same bits], `add_cin` = `carry_reg`. These hold stable for ADD_LAT+1 cycles.
- **ISSUE capture:** when `wcnt` equals ADD_LAT, capture `add_sum` into sum byte `idx` and `add_cout` into `carry_reg`, then clear `wcnt`.
  - If `idx` = 3, go to DONE.
  - Otherwise increment `idx`.
  - While `wcnt` is below ADD_LAT, increment `wcnt` instead.
- **DONE:**
  - `res_valid` = 1, and `res_sum`, `res_carry` (= `carry_reg`) and `res_id` are held stable.
  - On `res_ready` = 1, go to IDLE.
  - No request is accepted in the same cycle as the DONE exit.
- **Idle slice outputs:** outside ISSUE, `add_a`, `add_b` and `add_cin` are 0.
- **Requester obligation:** requesters hold valid, operands and cin until ready. A valid that drops before grant is simply not served.

## Timing
- **Reset values:**
  - State IDLE; `idx`, `wcnt` and `carry_reg` 0.
  - `last_id` = 1, so requester 0 wins the first tie.
  - All outputs 0: `res_valid`, `res_sum`, `res_carry`, `res_id`, `add_*` and `rN_ready`.
- **Reset mid-operation:** reset asserted in any state aborts the op immediately. No result is produced, and the first op after release is computed correctly.
- **Latency:** with accept at edge E0, `res_valid` rises after edge E0 + 4·(ADD_LAT+1). That is 8 cycles for ADD_LAT=1 and 4 cycles for ADD_LAT=0.
- **Throughput:** the minimum issue interval between accepts is 4·(ADD_LAT+1) + 2 cycles with `res_ready` tied high.
- **Backpressure:** `res_ready` held low keeps the block in DONE indefinitely. Both `rN_ready` stay 0 throughout.
- **Arbitration fairness:** under continuous contention, grants strictly alternate. A lone requester is granted back-to-back regardless of `last_id`.
- **Arithmetic:** there is no overflow flag; the carry ripples only through `carry_reg`.

## Test plan
- **Single-byte carry ripple:** ADD_LAT=1, r0: a=0x000000FF, b=0x00000001, cin=0. Required: `res_valid` 8 cycles after accept, `res_sum`=0x00000100, `res_carry`=0, `res_id`=0.
- **Full carry chain:** r1: a=0xFFFFFFFF, b=0, cin=1. Required: `res_sum`=0, `res_carry`=1, `res_id`=1.
- **Contention:** r0 and r1 both valid continuously, each with a distinct operand pair. Required: the grant order is 0,1,0,1 and each `res_sum` matches its requester.
- **Backpressure:** `res_ready` held low for 5 cycles in DONE. Required: `res_*` stable, `r0_ready`=`r1_ready`=0, then exit on the first `res_ready`=1.
- **Reset mid-op:** reset asserted while `idx`=2. Required: all outputs 0 next cycle, no `res_valid`, and the subsequent op 0x12345678 + 0x11111111 yields 0x23456789.
- **Combinational slice:** ADD_LAT=0 with a=0x12345678. Required: `add_a` sequence 0x78, 0x56, 0x34, 0x12 on consecutive cycles, and `res_valid` 4 cycles after accept.

Source files
------------

// File: rtl/adder_slice_scheduler.sv
// adder_slice_scheduler
// Runs 32-bit additions for two requesters through one external 8-bit adder
// slice. An accepted op is fed to the slice one byte at a time, byte 0 first.
// The carry between bytes is held in carry_r. The 32-bit result is then
// offered on a valid/ready port.
//
// Parameters:
//   ADD_LAT   slice latency in cycles (0..3). 0 means a combinational slice.
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   r0_valid/r0_ready         requester 0 handshake
//   r0_a, r0_b, r0_cin        requester 0 operands
//   r1_valid/r1_ready         requester 1 handshake
//   r1_a, r1_b, r1_cin        requester 1 operands
//   res_valid/res_ready       result handshake
//   res_sum, res_carry        32-bit sum and carry out of bit 31
//   res_id                    requester that issued the op
//   add_a, add_b, add_cin     operands driven to the slice
//   add_sum, add_cout         result returned by the slice
module adder_slice_scheduler #(
  parameter int ADD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r0_cin,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic        r1_cin,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_carry,
  output logic        res_id,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_cin,
  input  logic [7:0]  add_sum,
  input  logic        add_cout
);

  localparam logic [1:0] LAT_W = 2'(ADD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [1:0]  idx_r;
  logic [1:0]  wcnt_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] sum_r;
  logic        carry_r;
  logic        id_r;
  logic        last_id_r;

  logic        grant_valid_s;
  logic        grant_id_s;
  logic        accept_s;
  logic        capture_s;
  logic [4:0]  byte_lsb_s;

  // Arbitration: a lone requester always wins; on a tie the one not served last wins
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_id_r;
    end else if (r0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (r1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // Ready is masked during reset so every output reads 0 while reset is held
  assign accept_s   = (state_r == IDLE) && grant_valid_s && !reset;
  assign capture_s  = (state_r == ISSUE) && (wcnt_r == LAT_W);
  assign byte_lsb_s = {idx_r, 3'b000};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (capture_s && (idx_r == 2'd3)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ISSUE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand latch, byte/wait sub-state counters and result assembly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_r     <= 2'd0;
      wcnt_r    <= 2'd0;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      sum_r     <= 32'd0;
      carry_r   <= 1'b0;
      id_r      <= 1'b0;
      last_id_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r       <= grant_id_s ? r1_a : r0_a;
            b_r       <= grant_id_s ? r1_b : r0_b;
            carry_r   <= grant_id_s ? r1_cin : r0_cin;
            id_r      <= grant_id_s;
            last_id_r <= grant_id_s;
            sum_r     <= 32'd0;
            idx_r     <= 2'd0;
            wcnt_r    <= 2'd0;
          end
        end
        ISSUE: begin
          // The slice output is trusted only once the operands have been
          // held for ADD_LAT cycles; until then the wait counter advances.
          if (capture_s) begin
            sum_r[byte_lsb_s +: 8] <= add_sum;
            carry_r                <= add_cout;
            wcnt_r                 <= 2'd0;
            idx_r                  <= idx_r + 2'd1;
          end else begin
            wcnt_r <= wcnt_r + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: slice operands only in ISSUE, result fields only in DONE
  always_comb begin
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    add_a     = 8'd0;
    add_b     = 8'd0;
    add_cin   = 1'b0;
    res_valid = 1'b0;
    res_sum   = 32'd0;
    res_carry = 1'b0;
    res_id    = 1'b0;
    case (state_r)
      IDLE: begin
        r0_ready = accept_s && !grant_id_s;
        r1_ready = accept_s && grant_id_s;
      end
      ISSUE: begin
        add_a   = a_r[byte_lsb_s +: 8];
        add_b   = b_r[byte_lsb_s +: 8];
        add_cin = carry_r;
      end
      DONE: begin
        res_valid = 1'b1;
        res_sum   = sum_r;
        res_carry = carry_r;
        res_id    = id_r;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_adder_slice_scheduler.sv
// Testbench for adder_slice_scheduler. It drives two instances. The main
// instance uses ADD_LAT=1 and a registered slice model. The second instance
// uses ADD_LAT=0 and a combinational slice model. Expected results come from
// plain 33-bit arithmetic and a simple model of the arbitration order.
module tb_adder_slice_scheduler;

  localparam int LAT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic        r0_cin, r1_cin;
  logic        res_valid, res_ready, res_carry, res_id;
  logic [31:0] res_sum;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  logic        c_r0_valid, c_r1_valid, c_r0_ready, c_r1_ready;
  logic [31:0] c_r0_a, c_r0_b, c_r1_a, c_r1_b;
  logic        c_r0_cin, c_r1_cin;
  logic        c_res_valid, c_res_ready, c_res_carry, c_res_id;
  logic [31:0] c_res_sum;
  logic [7:0]  c_add_a, c_add_b, c_add_sum;
  logic        c_add_cin, c_add_cout;

  logic [53:0] outs;
  logic [8:0]  slice_pipe = 9'd0;

  int errors = 0;
  int checks = 0;
  bit last_m = 1'b1;

  always #5 clock = ~clock;

  adder_slice_scheduler #(.ADD_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_cin(r0_cin),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_cin(r1_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry), .res_id(res_id),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  adder_slice_scheduler #(.ADD_LAT(0)) dut_c (
    .clock(clock), .reset(reset),
    .r0_valid(c_r0_valid), .r0_ready(c_r0_ready), .r0_a(c_r0_a), .r0_b(c_r0_b), .r0_cin(c_r0_cin),
    .r1_valid(c_r1_valid), .r1_ready(c_r1_ready), .r1_a(c_r1_a), .r1_b(c_r1_b), .r1_cin(c_r1_cin),
    .res_valid(c_res_valid), .res_ready(c_res_ready), .res_sum(c_res_sum),
    .res_carry(c_res_carry), .res_id(c_res_id),
    .add_a(c_add_a), .add_b(c_add_b), .add_cin(c_add_cin),
    .add_sum(c_add_sum), .add_cout(c_add_cout)
  );

  // one-cycle slice for the main instance, combinational slice for dut_c
  always @(posedge clock) slice_pipe <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign {add_cout, add_sum} = slice_pipe;
  assign {c_add_cout, c_add_sum} = {1'b0, c_add_a} + {1'b0, c_add_b} + {8'd0, c_add_cin};

  assign outs = {res_valid, res_sum, res_carry, res_id, add_a, add_b, add_cin, r0_ready, r1_ready};

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  // Runs one op from a lone requester and reports what was observed.
  task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input int stall, output int wait_n, output int lat,
                       output logic [31:0] sum, output logic carry, output logic rid);
    res_ready = 1'b0;
    @(negedge clock);
    if (id) begin
      r1_valid = 1'b1; r1_a = a; r1_b = b; r1_cin = cin;
    end else begin
      r0_valid = 1'b1; r0_a = a; r0_b = b; r0_cin = cin;
    end
    #1;
    wait_n = 0;
    while (!(id ? r1_ready : r0_ready) && wait_n < 50) begin
      @(negedge clock); #1; wait_n++;
    end
    @(negedge clock);
    r0_valid = 1'b0; r1_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(negedge clock); lat++;
    end
    sum = res_sum; carry = res_carry; rid = res_id;
    repeat (stall) @(negedge clock);
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; res_ready = 1'b0; c_res_ready = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = 32'd0; r0_b = 32'd0; r0_cin = 1'b0; r1_a = 32'd0; r1_b = 32'd0; r1_cin = 1'b0;
    c_r0_valid = 1'b0; c_r1_valid = 1'b0; c_r0_a = 32'd0; c_r0_b = 32'd0; c_r0_cin = 1'b0;
    c_r1_a = 32'd0; c_r1_b = 32'd0; c_r1_cin = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (outs !== 54'd0) begin
      errors++; $display("FAIL reset_held: outputs got %h want 0", outs);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== 54'd0) begin
      errors++; $display("FAIL reset_release: outputs got %h want 0", outs);
    end
    last_m = 1'b1;
  endtask

  task automatic test_single(input bit id, input logic [31:0] a, input logic [31:0] b, input logic cin,
                             input logic [32:0] want, input string name);
    int w, lat; logic [31:0] s; logic c, rid;
    do_op(id, a, b, cin, 0, w, lat, s, c, rid);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL %s_ready: wait got %0d want 0", name, w); end
    checks++;
    if (lat !== 4 * (LAT + 1)) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, 4 * (LAT + 1)); end
    checks++;
    if (s !== want[31:0]) begin errors++; $display("FAIL %s_sum: got %h want %h", name, s, want[31:0]); end
    checks++;
    if (c !== want[32]) begin errors++; $display("FAIL %s_carry: got %b want %b", name, c, want[32]); end
    checks++;
    if (rid !== id) begin errors++; $display("FAIL %s_id: got %b want %b", name, rid, id); end
    last_m = id;
  endtask

  task automatic test_contention();
    logic [32:0] expq[$];
    bit          idq[$];
    int accepts = 0, results = 0, cyc = 0, last_acc = -1, pend = -1;
    bit g;
    logic [32:0] e;
    bit ei;
    res_ready = 1'b1;
    @(negedge clock);
    r0_valid = 1'b1; r0_a = $urandom; r0_b = $urandom; r0_cin = 1'($urandom_range(0, 1));
    r1_valid = 1'b1; r1_a = $urandom; r1_b = $urandom; r1_cin = 1'($urandom_range(0, 1));
    while (results < 4 && cyc < 200) begin
      #1;
      if (r0_ready || r1_ready) begin
        g = r1_ready;
        checks++;
        if ((r0_ready && r1_ready) || (g !== ~last_m)) begin
          errors++; $display("FAIL contention_grant: got r0=%b r1=%b want grant %b", r0_ready, r1_ready, ~last_m);
        end
        expq.push_back(g ? ref_add(r1_a, r1_b, r1_cin) : ref_add(r0_a, r0_b, r0_cin));
        idq.push_back(g);
        last_m = g;
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 4 * (LAT + 1) + 2) begin
            errors++; $display("FAIL contention_interval: got %0d want %0d", cyc - last_acc, 4 * (LAT + 1) + 2);
          end
        end
        last_acc = cyc; accepts++; pend = g;
      end
      if (res_valid) begin
        e = expq.pop_front(); ei = idq.pop_front();
        checks++;
        if ({res_carry, res_sum} !== e || res_id !== ei) begin
          errors++; $display("FAIL contention_result: got id=%b %b_%h want id=%b %b_%h",
                             res_id, res_carry, res_sum, ei, e[32], e[31:0]);
        end
        results++;
      end
      @(negedge clock); cyc++;
      if (pend >= 0) begin
        if (accepts >= 4) begin
          r0_valid = 1'b0; r1_valid = 1'b0;
        end else if (pend == 1) begin
          r1_a = $urandom; r1_b = $urandom; r1_cin = 1'($urandom_range(0, 1));
        end else begin
          r0_a = $urandom; r0_b = $urandom; r0_cin = 1'($urandom_range(0, 1));
        end
        pend = -1;
      end
    end
    checks++;
    if (results !== 4 || accepts !== 4) begin
      errors++; $display("FAIL contention_count: got acc=%0d res=%0d want 4/4", accepts, results);
    end
    res_ready = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [32:0] e;
    int n;
    res_ready = 1'b0;
    @(negedge clock);
    r0_valid = 1'b1; r0_a = $urandom; r0_b = $urandom; r0_cin = 1'($urandom_range(0, 1));
    e = ref_add(r0_a, r0_b, r0_cin);
    #1;
    n = 0;
    while (!r0_ready && n < 50) begin @(negedge clock); #1; n++; end
    @(negedge clock);
    r0_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clock); n++; end
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_a = $urandom; r1_a = $urandom;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (res_valid !== 1'b1 || {res_carry, res_sum} !== e || res_id !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b %b_%h id=%b want v=1 %b_%h id=0",
                           k, res_valid, res_carry, res_sum, res_id, e[32], e[31:0]);
      end
      checks++;
      if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready%0d: got r0=%b r1=%b want 0 0", k, r0_ready, r1_ready);
      end
      @(negedge clock);
    end
    res_ready = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_exit: res_valid got %b want 0", res_valid); end
    res_ready = 1'b0;
    last_m = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      bit id; logic [31:0] a, b; logic cin;
      id = 1'($urandom_range(0, 1));
      a = (i == 3) ? 32'hFFFF_FFFF : $urandom;
      b = $urandom;
      cin = 1'($urandom_range(0, 1));
      test_single(id, a, b, cin, ref_add(a, b, cin), "random");
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] a, b;
    int n, seen;
    a = $urandom; b = $urandom;
    @(negedge clock);
    r0_valid = 1'b1; r0_a = a; r0_b = b; r0_cin = 1'b0;
    #1;
    n = 0;
    while (!r0_ready && n < 50) begin @(negedge clock); #1; n++; end
    @(negedge clock);
    r0_valid = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (add_a !== a[23:16] || add_b !== b[23:16]) begin
      errors++; $display("FAIL midop_byte2: got %h/%h want %h/%h", add_a, add_b, a[23:16], b[23:16]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== 54'd0) begin errors++; $display("FAIL midop_reset_now: outputs got %h want 0", outs); end
    @(negedge clock);
    #1;
    checks++;
    if (outs !== 54'd0) begin errors++; $display("FAIL midop_reset_next: outputs got %h want 0", outs); end
    reset = 1'b0;
    last_m = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (res_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midop_no_result: res_valid cycles got %0d want 0", seen); end
    test_single(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, "after_reset");
  endtask

  task automatic test_comb();
    logic [31:0] a, b;
    logic [32:0] e;
    logic [7:0] want;
    int n;
    a = 32'h1234_5678; b = $urandom;
    c_res_ready = 1'b0;
    @(negedge clock);
    c_r0_valid = 1'b1; c_r0_a = a; c_r0_b = b; c_r0_cin = 1'($urandom_range(0, 1));
    e = ref_add(a, b, c_r0_cin);
    #1;
    n = 0;
    while (!c_r0_ready && n < 50) begin @(negedge clock); #1; n++; end
    @(negedge clock);
    c_r0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      want = 8'(a >> (8 * k));
      checks++;
      if (c_add_a !== want || c_res_valid !== 1'b0) begin
        errors++; $display("FAIL comb_byte%0d: got add_a=%h v=%b want %h v=0", k, c_add_a, c_res_valid, want);
      end
      @(negedge clock);
    end
    #1;
    checks++;
    if (c_res_valid !== 1'b1) begin errors++; $display("FAIL comb_latency: res_valid got %b want 1", c_res_valid); end
    checks++;
    if ({c_res_carry, c_res_sum} !== e || c_res_id !== 1'b0) begin
      errors++; $display("FAIL comb_result: got %b_%h id=%b want %b_%h id=0", c_res_carry, c_res_sum, c_res_id, e[32], e[31:0]);
    end
    c_res_ready = 1'b1;
    @(negedge clock);
    c_res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, "ripple");
    test_single(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000, "full_chain");
    test_contention();
    test_backpressure();
    test_random();
    test_reset_midop();
    test_comb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
